lab1q_prime_tester: RTL and testbench

- Responder end of the start_prime / done / prime handshake driven by the lab1q control FSM.
- Latches an unsigned ROM value on start and decides primality by trial division.
- Trial division uses repeated subtraction; no divider, and the divisor square is tracked incrementally, so no multiplier either.
- Presents a sticky done/prime result that the FSM samples in its wait state.

---
 rtl/lab1q_pkg.sv | 15 +
 rtl/lab1q_rem_unit.sv | 34 +++
 rtl/lab1q_prime_tester.sv | 159 +++++++++++++++
 tb/tb_lab1q_prime_tester.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lab1q_pkg.sv
// Shared definitions for the lab1q blocks: control-state encoding and the
// default ROM data width used by the ROM/RAM and prime-tester blocks.
package lab1q_pkg;

  localparam int LAB1Q_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MOD   = 3'd2,
    ST_TEST  = 3'd3,
    ST_DONE  = 3'd4
  } lab1q_state_t;

endpackage

// File: rtl/lab1q_rem_unit.sv
// Repeated-subtraction remainder engine. A load seeds the running remainder;
// each step subtracts the divisor while the remainder is not below it.
module lab1q_rem_unit
  import lab1q_pkg::*;
#(
  parameter int WIDTH = LAB1Q_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_r,
  output logic             o_r_lt_d
);

  logic [WIDTH-1:0] r_rem;

  // Remainder register: load has priority, a step never underflows.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
    end else if (i_load) begin
      r_rem <= i_load_val;
    end else if (i_step && !o_r_lt_d) begin
      r_rem <= r_rem - i_d;
    end
  end

  assign o_r      = r_rem;
  assign o_r_lt_d = (r_rem < i_d);

endmodule

// File: rtl/lab1q_prime_tester.sv
// lab1q prime tester: responder end of the start_prime/done/prime handshake.
// Latches num on an accepted start and decides primality by trial division
// using repeated subtraction and an incrementally tracked divisor square.
// Optional build macro LAB1Q_PRIME_ODD_STEP_EN: after divisor 2, only odd
// divisors are tried (same results, shorter test).
module lab1q_prime_tester
  import lab1q_pkg::*;
#(
  parameter int WIDTH = LAB1Q_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  output logic             done,
  output logic             prime,
  output logic             busy
);

  localparam int SQW = 2 * WIDTH;

  lab1q_state_t     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_n, w_n_nxt;
  logic [WIDTH-1:0] r_d, w_d_nxt;
  logic [SQW-1:0]   r_sq, w_sq_nxt;
  logic             r_done, w_done_nxt;
  logic             r_prime, w_prime_nxt;
  logic             r_busy, w_busy_nxt;

  logic             w_accept;
  logic             w_rem_load;
  logic [WIDTH-1:0] w_rem_val;
  logic             w_rem_step;
  logic [WIDTH-1:0] w_r;
  logic             w_r_lt_d;
  logic [SQW-1:0]   w_n_ext;
  logic [SQW-1:0]   w_d_ext;

  assign w_n_ext  = {{WIDTH{1'b0}}, r_n};
  assign w_d_ext  = {{WIDTH{1'b0}}, r_d};
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  lab1q_rem_unit #(.WIDTH(WIDTH)) u_rem (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_rem_load),
    .i_load_val (w_rem_val),
    .i_step     (w_rem_step),
    .i_d        (r_d),
    .o_r        (w_r),
    .o_r_lt_d   (w_r_lt_d)
  );

  // State, operand and handshake registers; reset aborts any test in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_d     <= '0;
      r_sq    <= '0;
      r_done  <= 1'b0;
      r_prime <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_n     <= w_n_nxt;
      r_d     <= w_d_nxt;
      r_sq    <= w_sq_nxt;
      r_done  <= w_done_nxt;
      r_prime <= w_prime_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic: trial-division sequencing plus start acceptance, which
  // overrides everything so a start seen in DONE restarts immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_d_nxt     = r_d;
    w_sq_nxt    = r_sq;
    w_done_nxt  = r_done;
    w_prime_nxt = r_prime;
    w_busy_nxt  = r_busy;
    w_rem_load  = 1'b0;
    w_rem_val   = r_n;
    w_rem_step  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      ST_CHECK: begin
        if (r_n < WIDTH'(2)) begin
          w_prime_nxt = 1'b0;
          w_state_nxt = ST_DONE;
        end else if (r_sq > w_n_ext) begin
          w_prime_nxt = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_rem_load  = 1'b1;
          w_rem_val   = r_n;
          w_state_nxt = ST_MOD;
        end
      end
      ST_MOD: begin
        if (!w_r_lt_d) begin
          w_rem_step = 1'b1;
        end else begin
          w_state_nxt = ST_TEST;
        end
      end
      ST_TEST: begin
        if (w_r == '0) begin
          w_prime_nxt = 1'b0;
          w_state_nxt = ST_DONE;
        end else begin
`ifdef LAB1Q_PRIME_ODD_STEP_EN
          if (r_d == WIDTH'(2)) begin
            w_d_nxt  = r_d + WIDTH'(1);
            w_sq_nxt = r_sq + (w_d_ext << 1) + SQW'(1);
          end else begin
            w_d_nxt  = r_d + WIDTH'(2);
            w_sq_nxt = r_sq + (w_d_ext << 2) + SQW'(4);
          end
`else
          w_d_nxt  = r_d + WIDTH'(1);
          w_sq_nxt = r_sq + (w_d_ext << 1) + SQW'(1);
`endif
          w_state_nxt = ST_CHECK;
        end
      end
      ST_DONE: begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_accept) begin
      w_n_nxt     = num;
      w_d_nxt     = WIDTH'(2);
      w_sq_nxt    = SQW'(4);
      w_rem_load  = 1'b1;
      w_rem_val   = num;
      w_done_nxt  = 1'b0;
      w_prime_nxt = 1'b0;
      w_busy_nxt  = 1'b1;
      w_state_nxt = ST_CHECK;
    end
  end

  assign done  = r_done;
  assign prime = r_prime;
  assign busy  = r_busy;

endmodule

// File: tb/tb_lab1q_prime_tester.sv
// Bench for lab1q_prime_tester: directed handshake scenarios plus random
// values, checked against an arithmetic primality / cycle-count model.
module tb_lab1q_prime_tester;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] num;
  logic       done;
  logic       prime;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef LAB1Q_PRIME_ODD_STEP_EN
  localparam bit ODD = 1'b1;
`else
  localparam bit ODD = 1'b0;
`endif

  lab1q_prime_tester #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .num   (num),
    .done  (done),
    .prime (prime),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic bit model_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++)
      if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Edges from the accepting edge until done reads high. Each tried divisor
  // costs one check, n/d subtractions, one exit from the subtraction loop and
  // one remainder test; a final check ends a prime search, and done is
  // registered one edge after the result is known.
  function automatic int model_lat(input int n, input bit odd);
    int lat;
    int k;
    if (n < 2) return 2;
    lat = 0;
    k   = 2;
    while (k * k <= n) begin
      lat += 1 + (n / k) + 1 + 1;
      if (n % k == 0) return lat + 1;
      k = (odd && k > 2) ? k + 2 : k + 1;
    end
    return lat + 2;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One handshake: pulse start, then poll done. Optionally pokes a second
  // start (num=100) after poll edge poke_at while the test is running.
  task automatic run_test(input int v, input int poke_at,
                          output int lat, output int busy_cyc, output logic pr);
    bit got;
    @(negedge clk);
    start = 1'b1;
    num   = 8'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    check($sformatf("done_low_after_start_%0d", v), int'(done), 0);
    busy_cyc = busy ? 1 : 0;
    lat      = 0;
    pr       = 1'b0;
    got      = 1'b0;
    if (poke_at == 0) begin
      start = 1'b0;
    end
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        pr  = prime;
        got = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      if (k == poke_at) begin
        start = 1'b1;
        num   = 8'd100;
      end
    end
    check($sformatf("done_seen_%0d", v), int'(got), 1);
    check($sformatf("busy_low_at_done_%0d", v), int'(busy), 0);
  endtask

  int   lat;
  int   bcyc;
  logic pr;
  int   found[$];
  int   exp_primes[11] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31};
  int   rv;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", int'(done), 0);
    check("reset_prime", int'(prime), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;

    // idle with no start: everything stays low
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle_done_%0d", i), int'(done), 0);
      check($sformatf("idle_busy_%0d", i), int'(busy), 0);
      check($sformatf("idle_prime_%0d", i), int'(prime), 0);
    end

    // small values finish two edges after acceptance
    for (int v = 0; v <= 2; v++) begin
      run_test(v, 0, lat, bcyc, pr);
      check($sformatf("small_prime_%0d", v), int'(pr), (v == 2) ? 1 : 0);
      check($sformatf("small_lat_%0d", v), lat, 2);
      check($sformatf("small_busy_%0d", v), bcyc, 2);
    end

    // directed composites and primes including the top of the range
    foreach (exp_primes[i]) begin end
    begin
      int dir[5] = '{4, 9, 97, 251, 255};
      foreach (dir[i]) begin
        run_test(dir[i], 0, lat, bcyc, pr);
        check($sformatf("dir_prime_%0d", dir[i]), int'(pr), int'(model_prime(dir[i])));
        check($sformatf("dir_lat_%0d", dir[i]), lat, model_lat(dir[i], ODD));
        check($sformatf("dir_busy_%0d", dir[i]), bcyc, lat);
        if (ODD && dir[i] == 251)
          check("odd_step_faster_251", int'(lat < model_lat(251, 1'b0)), 1);
      end
    end
    check("lat4_is_6", model_lat(4, ODD), 6);

    // start while busy is ignored
    run_test(97, 5, lat, bcyc, pr);
    check("busy_start_prime_97", int'(pr), 1);
    check("busy_start_lat_97", lat, model_lat(97, ODD));
    check("done_high_before_restart", int'(done), 1);

    // restart from DONE: done drops on the accepting edge (checked in task)
    run_test(13, 0, lat, bcyc, pr);
    check("restart_prime_13", int'(pr), 1);

    // reset while subtracting aborts the test
    @(negedge clk);
    start = 1'b1;
    num   = 8'd221;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_prime", int'(prime), 0);
    reset = 1'b0;
    run_test(13, 0, lat, bcyc, pr);
    check("after_abort_prime_13", int'(pr), 1);
    check("after_abort_lat_13", lat, model_lat(13, ODD));

    // handshake replay over ROM values 2..31
    for (int v = 2; v <= 31; v++) begin
      run_test(v, 0, lat, bcyc, pr);
      if (pr) found.push_back(v);
    end
    check("replay_count", found.size(), 11);
    foreach (exp_primes[i]) begin
      rv = (i < found.size()) ? found[i] : -1;
      check($sformatf("replay_prime_%0d", i), rv, exp_primes[i]);
    end

    // random values against the model
    for (int i = 0; i < 24; i++) begin
      rv = int'($urandom_range(0, 255));
      run_test(rv, 0, lat, bcyc, pr);
      check($sformatf("rand_prime_%0d", rv), int'(pr), int'(model_prime(rv)));
      check($sformatf("rand_lat_%0d", rv), lat, model_lat(rv, ODD));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
